// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU opcode constants and the operand-stage payload bundle.
// Imported by the operand stage and any later stage that decodes logic ops.
package alu_operand_stage_pkg;

  localparam logic [1:0] LOGIC_OP_AND = 2'b00;
  localparam logic [1:0] LOGIC_OP_OR  = 2'b01;
  localparam logic [1:0] LOGIC_OP_XOR = 2'b10;

  localparam int ALU_OPERAND_PAYLOAD_W = 72;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  logic_op;
    logic [4:0]  rd;
    logic        illegal;
  } alu_operand_t;

  function automatic logic logic_op_illegal(input logic [1:0] op);
    logic bad;
    bad = 1'b1;
    unique case (1'b1)
      (op == LOGIC_OP_AND): bad = 1'b0;
      (op == LOGIC_OP_OR):  bad = 1'b0;
      (op == LOGIC_OP_XOR): bad = 1'b0;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/alu_operand_stage_skid.sv
// Two-entry skid buffer: main register drives the output, skid absorbs
// the one entry accepted while main is stalled. Registered in_ready.
module skid_buffer #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v, skid_v;
  logic [W-1:0] main_d, skid_d;
  logic         main_v_n, skid_v_n;
  logic [W-1:0] main_d_n, skid_d_n;
  logic         acc, drain;

  assign acc       = in_valid && in_ready;
  assign drain     = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_d_n = main_d;
    skid_d_n = skid_d;
    if (skid_v) begin
      if (drain) begin
        main_d_n = skid_d;
        skid_v_n = acc;
        if (acc) skid_d_n = in_data;
      end
    end else if (!main_v || drain) begin
      main_v_n = acc;
      if (acc) main_d_n = in_data;
    end else if (acc) begin
      skid_v_n = 1'b1;
      skid_d_n = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_d   <= '0;
      skid_d   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      main_v   <= main_v_n;
      skid_v   <= skid_v_n;
      main_d   <= main_d_n;
      skid_d   <= skid_d_n;
      in_ready <= !skid_v_n;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand formation ahead of the ALU: B select, illegal-op flag,
// skid-buffered valid/ready output and a saturating stall counter.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_rs1_data,
  input  logic [31:0]            in_rs2_data,
  input  logic [31:0]            in_imm,
  input  logic                   in_use_imm,
  input  logic [1:0]             in_logic_op,
  input  logic [4:0]             in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic [1:0]             out_logic_op,
  output logic [4:0]             out_rd,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  alu_operand_t in_p, out_p;

  always_comb begin
    in_p.a        = in_rs1_data;
    in_p.b        = in_use_imm ? in_imm : in_rs2_data;
    in_p.logic_op = in_logic_op;
    in_p.rd       = in_rd;
    in_p.illegal  = logic_op_illegal(in_logic_op);
  end

  skid_buffer #(
    .W(ALU_OPERAND_PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_p)
  );

  assign out_a        = out_p.a;
  assign out_b        = out_p.b;
  assign out_logic_op = out_p.logic_op;
  assign out_rd       = out_p.rd;
  assign out_illegal  = out_p.illegal;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!flush && out_valid && !out_ready
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
